// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter and its helpers.
package dbus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // last_grant starts on the highest port so port 0 wins the first round.
  function automatic int last_grant_rst(input int num_ports);
    return num_ports - 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of pending after last_grant, with wrap-around.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_pending
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (!found && pending[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_pending = |pending;

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one single-outstanding data-memory port between NUM_PORTS
// pulse-protocol requesters, with an optional watchdog for transactions that never complete.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_wen,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
  input  logic [STRB_W*NUM_PORTS-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]        resp_ready,
  output logic [NUM_PORTS-1:0]        resp_err,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        mem_valid,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [STRB_W-1:0]           mem_wstrb,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata
);

  // Handshake: req_valid[p] is a one-cycle pulse, latched into slot p unless that slot is
  // already pending; resp_ready[p] is a one-cycle pulse with resp_rdata/resp_err. Downstream,
  // mem_valid pulses once per transaction and mem_ready pulses once when it completes.

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(last_grant_rst(NUM_PORTS));

  state_t state, state_nx;

  logic [NUM_PORTS-1:0]        pending, clr_vec, set_vec;
  logic [NUM_PORTS-1:0]        resp_ready_nx, resp_err_nx;
  logic [NUM_PORTS-1:0]        slot_wen;
  logic [ADDR_W*NUM_PORTS-1:0] slot_addr;
  logic [DATA_W*NUM_PORTS-1:0] slot_wdata;
  logic [STRB_W*NUM_PORTS-1:0] slot_wstrb;
  logic [IDX_W-1:0]            last_grant, grant_q, pick;
  logic [CNT_W-1:0]            cnt;
  logic                        any_pending, issue, done_ok, done_to, retire;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant       (pick),
    .any_pending (any_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue)  state_nx = WAIT;
      WAIT:    if (retire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A response clearing pending[p] and a new pulse on p at the same edge: the new one is kept.
  always_comb begin
    issue         = (state == IDLE) && any_pending;
    done_ok       = (state == WAIT) && mem_ready;
    done_to       = (TIMEOUT != 0) && (state == WAIT) && !mem_ready && (cnt == TO_LAST);
    retire        = done_ok || done_to;
    clr_vec       = retire ? (NUM_PORTS'(1) << grant_q) : '0;
    set_vec       = req_valid & (~pending | clr_vec);
    resp_ready_nx = clr_vec;
    resp_err_nx   = done_to ? clr_vec : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      slot_wen   <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      slot_wstrb <= '0;
      last_grant <= LAST_RST;
      grant_q    <= '0;
      cnt        <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      resp_ready <= '0;
      resp_err   <= '0;
      resp_rdata <= '0;
    end else begin
      pending    <= (pending & ~clr_vec) | set_vec;
      mem_valid  <= issue;
      resp_ready <= resp_ready_nx;
      resp_err   <= resp_err_nx;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (set_vec[p]) begin
          slot_wen[p]                     <= req_wen[p];
          slot_addr[p*ADDR_W +: ADDR_W]   <= req_addr[p*ADDR_W +: ADDR_W];
          slot_wdata[p*DATA_W +: DATA_W]  <= req_wdata[p*DATA_W +: DATA_W];
          slot_wstrb[p*STRB_W +: STRB_W]  <= req_wstrb[p*STRB_W +: STRB_W];
        end
      end
      if (issue) begin
        grant_q   <= pick;
        cnt       <= '0;
        mem_wen   <= slot_wen[pick];
        mem_addr  <= slot_addr[int'(pick)*ADDR_W +: ADDR_W];
        mem_wdata <= slot_wdata[int'(pick)*DATA_W +: DATA_W];
        mem_wstrb <= slot_wstrb[int'(pick)*STRB_W +: STRB_W];
      end else if (state == WAIT && !mem_ready) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done_ok)      resp_rdata <= mem_rdata;
      else if (done_to) resp_rdata <= '0;
      if (retire) last_grant <= grant_q;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dbus_arbiter;

  localparam int NP = 2;
  localparam int TO = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NP-1:0]       req_valid = '0, req_wen = '0;
  logic [32*NP-1:0]    req_addr = '0, req_wdata = '0;
  logic [4*NP-1:0]     req_wstrb = '0;
  logic [NP-1:0]       resp_ready, resp_err;
  logic [31:0]         resp_rdata;
  logic                mem_valid, mem_wen;
  logic [31:0]         mem_addr, mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_ready = 1'b0;
  logic [31:0]         mem_rdata = '0;

  dbus_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_ready (resp_ready),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_valid  (mem_valid),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mvalid;
    logic          wen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [NP-1:0] rready;
    logic [NP-1:0] rerr;
    logic [31:0]   rdata;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  // driver state
  logic [NP-1:0] drv_valid = '0, drv_wen = '0;
  logic [31:0]   drv_addr[NP], drv_wdata[NP];
  logic [3:0]    drv_wstrb[NP];
  logic [NP-1:0] rereq_mask = '0, b2b_mask = '0;
  bit            rand_req = 0, spur = 0, use_force_rdata = 0;
  logic [31:0]   force_rdata = '0;
  int            d_q[$];

  // reference model: request slots, round-robin pointer, the one open transaction
  bit            m_pend[NP];
  logic          m_wen[NP];
  logic [31:0]   m_addr[NP], m_wdata[NP];
  logic [3:0]    m_wstrb[NP];
  int            m_last, m_g, m_wcnt, m_d;
  bit            m_busy;
  logic [31:0]   m_rdata_plan;

  // observation logs
  int n_total = 0, n_bad = 0, cyc = 0, err_cnt = 0;
  int mv_cyc[$], rs_cyc[$], rs_port[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    drv_valid[p] = 1'b1;
    drv_wen[p]   = wen;
    drv_addr[p]  = addr;
    drv_wdata[p] = wdata;
    drv_wstrb[p] = wstrb;
  endtask

  task automatic rand_req_port(input int p);
    set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= NP; i++) begin
      if (m_pend[(m_last + i) % NP]) return (m_last + i) % NP;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_pend[p] = 0;
    m_last = NP - 1;
    m_busy = 0;
    m_g = 0;
    m_wcnt = 0;
    m_d = 0;
  endtask

  // Advance the model across one clock edge with the inputs just applied; queue next-cycle outputs.
  task automatic model_step();
    exp_t          n;
    logic [NP-1:0] clr;
    int            g;
    n = '0;
    clr = '0;
    if (!m_busy) begin
      g = rr_pick();
      if (g >= 0) begin
        n.mvalid = 1'b1;
        n.wen    = m_wen[g];
        n.addr   = m_addr[g];
        n.wdata  = m_wdata[g];
        n.wstrb  = m_wstrb[g];
        m_busy   = 1;
        m_g      = g;
        m_wcnt   = 0;
        m_d      = (d_q.size() > 0) ? d_q.pop_front() : int'($urandom_range(0, 5));
        m_rdata_plan = use_force_rdata ? force_rdata : $urandom;
      end
    end else if (mem_ready) begin
      clr      = NP'(1) << m_g;
      n.rready = clr;
      n.rdata  = m_rdata_plan;
    end else begin
      m_wcnt++;
      if (m_wcnt == TO) begin
        clr      = NP'(1) << m_g;
        n.rready = clr;
        n.rerr   = clr;
        n.rdata  = '0;
      end
    end
    if (clr != '0) begin
      m_last = m_g;
      m_busy = 0;
    end
    for (int p = 0; p < NP; p++) if (clr[p]) m_pend[p] = 0;
    for (int p = 0; p < NP; p++) begin
      if (drv_valid[p] && !m_pend[p]) begin
        m_pend[p]  = 1;
        m_wen[p]   = drv_wen[p];
        m_addr[p]  = drv_addr[p];
        m_wdata[p] = drv_wdata[p];
        m_wstrb[p] = drv_wstrb[p];
      end
    end
    exp_q.push_back(n);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'(exp_q.size()), 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("mem_valid", 64'(mem_valid), 64'(e.mvalid));
    check("resp_ready", 64'(resp_ready), 64'(e.rready));
    check("resp_err", 64'(resp_err), 64'(e.rerr));
    if (e.mvalid) begin
      check("mem_addr", 64'(mem_addr), 64'(e.addr));
      check("mem_wen", 64'(mem_wen), 64'(e.wen));
      check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      check("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
    end
    if (|e.rready) check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
    if (mem_valid) mv_cyc.push_back(cyc);
    for (int p = 0; p < NP; p++) begin
      if (resp_ready[p]) begin
        rs_cyc.push_back(cyc);
        rs_port.push_back(p);
      end
    end
    if (|resp_err) err_cnt++;

    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (m_busy && m_wcnt == m_d && m_d < TO) begin
      mem_ready = 1'b1;
      mem_rdata = m_rdata_plan;
      if (b2b_mask[m_g]) rand_req_port(m_g);
    end else if (!m_busy && spur) begin
      mem_ready = 1'b1;
    end
    for (int p = 0; p < NP; p++) if (rereq_mask[p] && e.rready[p]) rand_req_port(p);
    if (rand_req) begin
      for (int p = 0; p < NP; p++) if ($urandom_range(0, 2) == 0) rand_req_port(p);
    end

    req_valid = drv_valid;
    req_wen   = drv_wen;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*32 +: 32] = drv_addr[p];
      req_wdata[p*32 +: 32] = drv_wdata[p];
      req_wstrb[p*4 +: 4]  = drv_wstrb[p];
    end
    model_step();
    drv_valid = '0;
    spur = 0;
  endtask

  // Reset is raised between edges to show the outputs clear without waiting for a clock.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    req_valid = '0;
    mem_ready = 1'b0;
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_resp_ready", 64'(resp_ready), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    model_reset();
    exp_q.delete();
    d_q.delete();
    mv_cyc.delete();
    rs_cyc.delete();
    rs_port.delete();
    err_cnt = 0;
    rereq_mask = '0;
    b2b_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('0);
  endtask

  initial begin
    int c0;
    for (int p = 0; p < NP; p++) begin
      drv_addr[p] = '0;
      drv_wdata[p] = '0;
      drv_wstrb[p] = '0;
    end
    model_reset();

    // single read with fixed memory latency
    apply_reset();
    d_q.push_back(2);
    use_force_rdata = 1;
    force_rdata = 32'hDEAD_BEEF;
    set_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    tick();
    c0 = cyc;
    repeat (7) tick();
    use_force_rdata = 0;
    check("rd_issue_lat", 64'((mv_cyc.size() > 0) ? mv_cyc[0] - c0 : -1), 64'd2);
    check("rd_resp_lat", 64'((rs_cyc.size() > 0) ? rs_cyc[0] - c0 : -1), 64'd5);

    // simultaneous write on port 0 and read on port 1
    apply_reset();
    d_q.push_back(1);
    d_q.push_back(1);
    set_req(0, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0011);
    set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    repeat (12) tick();
    check("sim_count", 64'(rs_port.size()), 64'd2);
    if (rs_port.size() >= 2) begin
      check("sim_first", 64'(rs_port[0]), 64'd0);
      check("sim_second", 64'(rs_port[1]), 64'd1);
    end

    // fairness: both ports re-request as soon as they are answered
    apply_reset();
    rereq_mask = '1;
    rand_req_port(0);
    rand_req_port(1);
    tick();
    for (int i = 0; i < 300 && rs_port.size() < 10; i++) tick();
    check("fair_count", 64'(rs_port.size() >= 10), 64'd1);
    for (int i = 0; i < 10 && i < rs_port.size(); i++) check("fair_alt", 64'(rs_port[i]), 64'(i % 2));
    rereq_mask = '0;
    repeat (20) tick();

    // back-to-back: port 1 pulses on the same edge that returns its response
    apply_reset();
    repeat (4) d_q.push_back(1);
    b2b_mask = 2'b10;
    rand_req_port(1);
    tick();
    repeat (12) tick();
    b2b_mask = '0;
    repeat (15) tick();
    if (mv_cyc.size() >= 2 && rs_cyc.size() >= 1)
      check("b2b_gap", 64'(mv_cyc[1] - rs_cyc[0]), 64'd1);
    else
      check("b2b_seen", 64'(mv_cyc.size()), 64'd2);

    // watchdog: port 0 never completes, port 1 is served after the error
    apply_reset();
    d_q.push_back(5);
    d_q.push_back(1);
    rand_req_port(0);
    rand_req_port(1);
    tick();
    c0 = cyc;
    repeat (14) tick();
    check("to_err_cnt", 64'(err_cnt), 64'd1);
    check("to_resp_cnt", 64'(rs_port.size()), 64'd2);
    if (rs_port.size() >= 2) begin
      check("to_lat", 64'(rs_cyc[0] - c0), 64'd6);
      check("to_first_port", 64'(rs_port[0]), 64'd0);
      check("to_next_port", 64'(rs_port[1]), 64'd1);
    end

    // reset while waiting, then a stray mem_ready must produce nothing
    apply_reset();
    d_q.push_back(5);
    rand_req_port(0);
    tick();
    repeat (3) tick();
    apply_reset();
    spur = 1;
    tick();
    repeat (6) tick();
    check("rst_wait_resp", 64'(rs_port.size()), 64'd0);
    check("rst_wait_issue", 64'(mv_cyc.size()), 64'd0);

    // random traffic with varied latency, timeouts and stray mem_ready in idle
    apply_reset();
    rand_req = 1;
    repeat (1500) begin
      spur = ($urandom_range(0, 7) == 0);
      tick();
    end
    rand_req = 0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish by 1ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
